// File: rtl/compression_mem_arbiter.sv
// compression_mem_arbiter
// Shares one single-port frame memory between the capture writer (port A)
// and the compression engine (port B). Grants are round-robin with a bounded
// burst. Out-of-range accesses are acknowledged but never reach the memory;
// they are flagged and counted instead. Read data is steered back to the
// requester that issued the read, one cycle after acceptance.
module compression_mem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 51200,
   parameter int BURST_MAX = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,

   input  logic                  a_req_i,
   input  logic                  a_write_i,
   input  logic [ADDR_W-1:0]     a_address_i,
   input  logic [DATA_W/8-1:0]   a_byteenable_i,
   input  logic [DATA_W-1:0]     a_writedata_i,
   output logic                  a_ack_o,
   output logic                  a_rvalid_o,
   output logic [DATA_W-1:0]     a_readdata_o,

   input  logic                  b_req_i,
   input  logic                  b_write_i,
   input  logic [ADDR_W-1:0]     b_address_i,
   input  logic [DATA_W/8-1:0]   b_byteenable_i,
   input  logic [DATA_W-1:0]     b_writedata_i,
   output logic                  b_ack_o,
   output logic                  b_rvalid_o,
   output logic [DATA_W-1:0]     b_readdata_o,

   output logic                  mem_chipselect_o,
   output logic                  mem_write_o,
   output logic [ADDR_W-1:0]     mem_address_o,
   output logic [DATA_W/8-1:0]   mem_byteenable_o,
   output logic [DATA_W-1:0]     mem_writedata_o,
   input  logic [DATA_W-1:0]     mem_readdata_i,

   output logic                  err_o,
   output logic [15:0]           err_count_o
);

   localparam int BE_W = DATA_W / 8;
   localparam int SW   = $clog2(BURST_MAX + 1);

   // Requester select encoding: index 0 is A, index 1 is B.
   localparam logic SEL_A = 1'b0;

   // Read-in-flight tag.
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_A    = 2'd1;
   localparam logic [1:0] TAG_B    = 2'd2;

   localparam logic [SW-1:0]   STREAK_MAX = SW'(BURST_MAX);
   localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W + 1)'(DEPTH);
   localparam logic [15:0]     CNT_MAX    = 16'hFFFF;

   // Requester inputs gathered into arrays so the grant mux is a simple index.
   logic [1:0]        req;
   logic              wr_in   [2];
   logic [ADDR_W-1:0] addr_in [2];
   logic [BE_W-1:0]   be_in   [2];
   logic [DATA_W-1:0] wd_in   [2];

   assign req        = {b_req_i, a_req_i};
   assign wr_in[0]   = a_write_i;
   assign wr_in[1]   = b_write_i;
   assign addr_in[0] = a_address_i;
   assign addr_in[1] = b_address_i;
   assign be_in[0]   = a_byteenable_i;
   assign be_in[1]   = b_byteenable_i;
   assign wd_in[0]   = a_writedata_i;
   assign wd_in[1]   = b_writedata_i;

   // Arbitration state.
   logic              owner_q, owner_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic [1:0]        rd_tag_q, rd_tag_d;
   logic              rd_oor_q, rd_oor_d;
   logic              err_q, err_d;
   logic [15:0]       err_count_q, err_count_d;

   // Grant decode.
   logic [1:0]        grant;
   logic              any_grant;
   logic              gsel;
   logic              g_write;
   logic [ADDR_W-1:0] g_addr;
   logic [BE_W-1:0]   g_be;
   logic [DATA_W-1:0] g_wd;
   logic              g_in_range;
   logic              mem_go;
   logic              oor_acc;

   // Pick the winner: a lone requester always wins; under contention the
   // owner keeps the port until its streak reaches BURST_MAX.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b01) begin
         grant = 2'b01;
      end else if (req == 2'b10) begin
         grant = 2'b10;
      end else if (req == 2'b11) begin
         if (streak_q < STREAK_MAX) begin
            grant = (owner_q == SEL_A) ? 2'b01 : 2'b10;
         end else begin
            grant = (owner_q == SEL_A) ? 2'b10 : 2'b01;
         end
      end
   end

   assign any_grant  = |grant;
   assign gsel       = grant[1];
   assign a_ack_o    = grant[0];
   assign b_ack_o    = grant[1];

   assign g_write    = wr_in[gsel];
   assign g_addr     = addr_in[gsel];
   assign g_be       = be_in[gsel];
   assign g_wd       = wd_in[gsel];
   assign g_in_range = ({1'b0, g_addr} < DEPTH_L);
   assign mem_go     = any_grant & g_in_range;
   assign oor_acc    = any_grant & ~g_in_range;

   // The memory bus is forced to all-zero unless a legal access is granted,
   // so out-of-range writes are silently dropped.
   assign mem_chipselect_o = mem_go;
   assign mem_write_o      = mem_go & g_write;
   assign mem_address_o    = mem_go ? g_addr : '0;
   assign mem_byteenable_o = mem_go ? g_be   : '0;
   assign mem_writedata_o  = mem_go ? g_wd   : '0;

   // Next owner/streak: idle clears the streak, a switch restarts it at 1,
   // a repeat grant counts up and saturates.
   always_comb begin
      owner_d  = owner_q;
      streak_d = streak_q;
      if (!any_grant) begin
         streak_d = '0;
      end else if (gsel == owner_q) begin
         if (streak_q < STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
         end
      end else begin
         owner_d  = gsel;
         streak_d = SW'(1);
      end
   end

   // Next read tag, error pulse and saturating error count.
   always_comb begin
      rd_tag_d    = TAG_NONE;
      rd_oor_d    = 1'b0;
      err_d       = oor_acc;
      err_count_d = err_count_q;
      if (any_grant && !g_write) begin
         rd_tag_d = gsel ? TAG_B : TAG_A;
         rd_oor_d = ~g_in_range;
      end
      if (oor_acc && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   // State registers; reset also discards any read in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         owner_q     <= SEL_A;
         streak_q    <= '0;
         rd_tag_q    <= TAG_NONE;
         rd_oor_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         rd_tag_q    <= rd_tag_d;
         rd_oor_q    <= rd_oor_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   // Read return: only the tagged requester sees data; an out-of-range read
   // still pulses rvalid but returns zero instead of stale memory output.
   logic              rvalid  [2];
   logic [DATA_W-1:0] rdata   [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      localparam logic [1:0] MY_TAG = (gi == 0) ? TAG_A : TAG_B;
      assign rvalid[gi] = (rd_tag_q == MY_TAG);
      assign rdata[gi]  = (rvalid[gi] && !rd_oor_q) ? mem_readdata_i : '0;
   end

   assign a_rvalid_o   = rvalid[0];
   assign a_readdata_o = rdata[0];
   assign b_rvalid_o   = rvalid[1];
   assign b_readdata_o = rdata[1];

   assign err_o        = err_q;
   assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_compression_mem_arbiter.sv
// Bench for compression_mem_arbiter: a frame-memory model on the mem_* side,
// a behavioural reference checked on every falling edge, and directed
// scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_compression_mem_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 51200;
   localparam int BMAX  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_req, a_write, b_req, b_write;
   logic [AW-1:0] a_addr, b_addr;
   logic [BW-1:0] a_be, b_be;
   logic [DW-1:0] a_wd, b_wd;
   logic          a_ack, a_rvalid, b_ack, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          mem_cs, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_be;
   logic [DW-1:0] mem_wd, mem_rdata;
   logic          err;
   logic [15:0]   err_count;

   compression_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .BURST_MAX(BMAX)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .a_req_i(a_req), .a_write_i(a_write), .a_address_i(a_addr),
      .a_byteenable_i(a_be), .a_writedata_i(a_wd),
      .a_ack_o(a_ack), .a_rvalid_o(a_rvalid), .a_readdata_o(a_rdata),
      .b_req_i(b_req), .b_write_i(b_write), .b_address_i(b_addr),
      .b_byteenable_i(b_be), .b_writedata_i(b_wd),
      .b_ack_o(b_ack), .b_rvalid_o(b_rvalid), .b_readdata_o(b_rdata),
      .mem_chipselect_o(mem_cs), .mem_write_o(mem_wr), .mem_address_o(mem_addr),
      .mem_byteenable_o(mem_be), .mem_writedata_o(mem_wd), .mem_readdata_i(mem_rdata),
      .err_o(err), .err_count_o(err_count)
   );

   // Frame memory: single port, registered read.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_cs) begin
         if (mem_wr) begin
            for (int i = 0; i < BW; i++)
               if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wd[8*i +: 8];
         end else begin
            mem_rdata <= ram[mem_addr];
         end
      end
   end

   int checks   = 0;
   int failures = 0;
   bit verbose  = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the memory as the masters see it, the running length of
   // the current grant streak, and what the next cycle must show.
   logic [DW-1:0] shadow [int];
   int            last_who;
   int            run_len;
   bit            exp_rv [2];
   logic [DW-1:0] exp_rd [2];
   bit            exp_err;
   int            exp_cnt;

   function automatic logic [DW-1:0] shadow_rd(input int addr);
      return shadow.exists(addr) ? shadow[addr] : '0;
   endfunction

   always @(negedge clk) begin
      int            g;
      bit            gw, inr;
      logic [AW-1:0] ga;
      logic [BW-1:0] gbe;
      logic [DW-1:0] gwd, w;
      logic [53:0]   exp_bus;
      if (rst) begin
         chk("rst_ack", {a_ack, b_ack}, 0);
         chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
         chk("rst_err", err, 0);
         chk("rst_err_count", err_count, 0);
         chk("rst_mem_cs", mem_cs, 0);
         last_who = 0; run_len = 0; exp_err = 0; exp_cnt = 0;
         exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = '0; exp_rd[1] = '0;
      end else begin
         if (a_req && !b_req)      g = 0;
         else if (b_req && !a_req) g = 1;
         else if (a_req && b_req)  g = (run_len < BMAX) ? last_who : 1 - last_who;
         else                      g = -1;
         gw  = (g == 1) ? b_write : a_write;
         ga  = (g == 1) ? b_addr  : a_addr;
         gbe = (g == 1) ? b_be    : a_be;
         gwd = (g == 1) ? b_wd    : a_wd;
         inr = (int'(ga) < DEPTH);

         chk("a_ack", a_ack, g == 0);
         chk("b_ack", b_ack, g == 1);
         chk("a_rvalid", a_rvalid, exp_rv[0]);
         chk("b_rvalid", b_rvalid, exp_rv[1]);
         chk("a_readdata", a_rdata, exp_rd[0]);
         chk("b_readdata", b_rdata, exp_rd[1]);
         chk("err", err, exp_err);
         chk("err_count", err_count, exp_cnt);
         exp_bus = (g >= 0 && inr) ? {1'b1, gw, ga, gbe, gwd} : '0;
         chk("mem_bus", {mem_cs, mem_wr, mem_addr, mem_be, mem_wd}, exp_bus);

         exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = '0; exp_rd[1] = '0; exp_err = 0;
         if (g < 0) begin
            run_len = 0;
         end else begin
            if (g == last_who) run_len++;
            else begin last_who = g; run_len = 1; end
            if (!gw) begin
               exp_rv[g] = 1;
               exp_rd[g] = inr ? shadow_rd(int'(ga)) : '0;
            end else if (inr) begin
               w = shadow_rd(int'(ga));
               for (int i = 0; i < BW; i++)
                  if (gbe[i]) w[8*i +: 8] = gwd[8*i +: 8];
               shadow[int'(ga)] = w;
            end
            if (!inr) begin
               exp_err = 1;
               if (exp_cnt < 65535) exp_cnt++;
            end
            if (verbose)
               $display("txn t=%0t port=%s %s addr=0x%04h be=0x%h wdata=0x%08h range=%s",
                        $time, (g == 0) ? "A" : "B", gw ? "WR" : "RD", ga, gbe, gwd,
                        inr ? "ok" : "oor");
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_a(input bit rq, input bit wr, input logic [AW-1:0] ad,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
      a_req = rq; a_write = wr; a_addr = ad; a_be = be; a_wd = d;
   endtask

   task automatic set_b(input bit rq, input bit wr, input logic [AW-1:0] ad,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
      b_req = rq; b_write = wr; b_addr = ad; b_be = be; b_wd = d;
   endtask

   task automatic idle();
      set_a(0, 0, '0, '0, '0);
      set_b(0, 0, '0, '0, '0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1.5ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_a, wait_b, max_wait;
      bit want_a;
      idle();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("reset_err_count", err_count, 0);
      chk("reset_rvalid", {a_rvalid, b_rvalid}, 0);

      // Single read: A writes, B reads it back one cycle later.
      set_a(1, 1, 16'h0010, 4'hF, 32'hDEADBEEF);
      @(negedge clk); #1;
      chk("wr_a_ack", a_ack, 1);
      chk("wr_mem_cs", mem_cs, 1);
      step();
      set_a(0, 0, '0, '0, '0);
      set_b(1, 0, 16'h0010, '0, '0);
      @(negedge clk); #1;
      chk("rd_b_ack", b_ack, 1);
      step();
      idle();
      chk("rd_b_rvalid", b_rvalid, 1);
      chk("rd_b_data", b_rdata, 32'hDEADBEEF);
      chk("rd_a_rvalid", a_rvalid, 0);

      // Byte enables, also write-then-read in consecutive cycles.
      set_a(1, 1, 16'h0020, 4'hF, 32'hFFFFFFFF); step();
      set_a(1, 1, 16'h0020, 4'h5, 32'h00000000); step();
      set_a(1, 0, 16'h0020, 4'h0, 32'h00000000); step();
      idle();
      chk("be_rvalid", a_rvalid, 1);
      chk("be_data", a_rdata, 32'hFF00FF00);

      // Contention from reset: 16 grants to A, 16 to B, repeating.
      rst = 1'b1; step(); step(); rst = 1'b0;
      set_a(1, 0, 16'h0010, '0, '0);
      set_b(1, 0, 16'h0020, '0, '0);
      wait_a = 0; wait_b = 0; max_wait = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk); #1;
         want_a = ((i / 16) % 2) == 0;
         chk($sformatf("arb_a_ack[%0d]", i), a_ack, want_a);
         chk($sformatf("arb_b_ack[%0d]", i), b_ack, !want_a);
         wait_a = a_ack ? 0 : wait_a + 1;
         wait_b = b_ack ? 0 : wait_b + 1;
         if (wait_a > max_wait) max_wait = wait_a;
         if (wait_b > max_wait) max_wait = wait_b;
      end
      chk("arb_max_wait_le_16", max_wait <= BMAX, 1);
      step();
      idle();

      // Out-of-range read by A right after B read a nonzero word.
      set_b(1, 0, 16'h0010, '0, '0); step();
      set_b(0, 0, '0, '0, '0);
      set_a(1, 0, 16'd51200, '0, '0);
      @(negedge clk); #1;
      chk("oor_a_ack", a_ack, 1);
      chk("oor_mem_cs", mem_cs, 0);
      step();
      idle();
      chk("oor_a_rvalid", a_rvalid, 1);
      chk("oor_a_rdata", a_rdata, 0);
      chk("oor_err", err, 1);
      chk("oor_err_count", err_count, 1);

      // A read accepted while B's write is pending; B follows next cycle.
      set_a(1, 0, 16'h0010, '0, '0);
      set_b(1, 1, 16'h0030, 4'hF, 32'h12345678);
      @(negedge clk); #1;
      chk("sim_a_ack", a_ack, 1);
      chk("sim_b_wait", b_ack, 0);
      step();
      set_a(0, 0, '0, '0, '0);
      chk("sim_a_rdata", a_rdata, 32'hDEADBEEF);
      @(negedge clk); #1;
      chk("sim_b_ack", b_ack, 1);
      chk("sim_a_rvalid_with_b_ack", a_rvalid, 1);
      step();
      idle();
      set_a(1, 0, 16'h0030, '0, '0); step();
      idle();
      chk("sim_b_write_landed", a_rdata, 32'h12345678);

      // Reset asserted after acceptance, before the capturing edge.
      set_a(1, 0, 16'h0010, '0, '0);
      @(negedge clk); #1;
      chk("rst_rd_ack", a_ack, 1);
      #2;
      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_rd_no_rvalid", a_rvalid, 0);
      step();
      rst = 1'b0;

      // Reset asserted asynchronously while rvalid is already high.
      set_a(1, 0, 16'h0020, '0, '0); step();
      idle();
      chk("async_pre_rvalid", a_rvalid, 1);
      chk("async_pre_rdata", a_rdata, 32'hFF00FF00);
      #1 rst = 1'b1;
      #1 chk("async_rvalid_cleared", a_rvalid, 0);
      step();
      rst = 1'b0;

      // Saturation of the error counter.
      verbose = 1'b0;
      $display("txn burst: 65538 out-of-range accesses on port A");
      for (int i = 0; i < 65538; i++) begin
         set_a(1, i[0], AW'(DEPTH + (i % 14336)), 4'hF, 32'hA5A5A5A5);
         step();
      end
      idle();
      verbose = 1'b1;
      chk("sat_err_count", err_count, 16'hFFFF);
      chk("sat_err_pulse", err, 1);
      chk("sat_model_pin", exp_cnt, 65535);
      step();
      chk("sat_err_low", err, 0);
      chk("sat_err_count_hold", err_count, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/compression_mem_arbiter.md
# compression_mem_arbiter

Two-requester arbiter that shares the single-port 32-bit on-chip frame memory (51200 words, 1-cycle read latency) between the capture writer (port A) and the compression engine (port B). Round-robin arbitration with a bounded burst length gives each requester at most one access per cycle. The block also enforces the address range, routes read data back to the requester that issued the read, and counts range errors. It sits between the two masters and the memory's s1 slave port.

## Interface

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 51200, number of valid words; addresses >= DEPTH are out of range.
- BURST_MAX, 16, maximum consecutive grants to one requester while the other waits.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- a_req / b_req  in  1  request valid, held until acknowledged.
- a_write / b_write  in  1  1 = write, 0 = read.
- a_address / b_address  in  ADDR_W  word address.
- a_byteenable / b_byteenable  in  DATA_W/8  byte lanes for writes.
- a_writedata / b_writedata  in  DATA_W  write data.
- a_ack / b_ack  out  1  combinational; request accepted this cycle.
- a_rvalid / b_rvalid  out  1  registered; read data valid.
- a_readdata / b_readdata  out  DATA_W  read data, meaningful only while the matching rvalid is 1.
- mem_chipselect  out  1  memory access this cycle.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory address.
- mem_byteenable  out  DATA_W/8  memory byte enables.
- mem_writedata  out  DATA_W  memory write data.
- mem_readdata  in  DATA_W  memory output, valid 1 cycle after the address is presented.
- err  out  1  registered; 1-cycle pulse after an out-of-range access is accepted.
- err_count  out  16  saturating count of out-of-range accesses.

## Operation

**State.** The block holds three registers:
- owner: the last requester granted. Reset value is A.
- streak: the number of consecutive grants to owner, 0..BURST_MAX. Reset value is 0.
- rd_tag: which requester owns the read in flight, one of none, A or B.

**Grant selection (combinational).**
- Only one requester has req=1: that requester is granted.
- Both have req=1 and streak < BURST_MAX: owner is granted.
- Both have req=1 and streak == BURST_MAX: the non-owner is granted.
- Exactly one of a_ack / b_ack is 1 when any req is 1. Both are 0 when neither req is 1.

**Register updates on a grant.**
- Grant to owner: streak increments, saturating at BURST_MAX.
- Grant to the other requester: owner switches to it and streak becomes 1.
- No grant (idle cycle): owner is kept and streak becomes 0.

**Memory drive.**
- The granted requester's write, address, byteenable and writedata are muxed onto the mem_* outputs.
- mem_chipselect is 1 only if the granted address < DEPTH.
- When nothing is granted, or the address is out of range, all mem_* outputs are 0.

**Read return.**
- An accepted read sets rd_tag to the granted requester. Any other cycle sets rd_tag to none.
- Next cycle, the tagged requester sees rvalid=1 with readdata = mem_readdata.
- For an out-of-range read, readdata = 0 and rvalid still pulses.
- A non-tagged requester's readdata is 0.

**Range error.**
- An out-of-range access is acknowledged normally but never reaches the memory; an out-of-range write is dropped.
- err pulses 1 in the next cycle.
- err_count increments and saturates at 0xFFFF.

**Reset.** Asserting reset at any time forces all registers and registered outputs (rvalid, err, err_count, owner, streak, rd_tag) to their reset values immediately. A read in flight is discarded: no rvalid follows.

## Timing

- Accept latency: 0 cycles. ack is asserted in the same cycle as req when the requester is granted.
- Read latency: rvalid follows exactly 1 cycle after the ack.
- Throughput: 1 access per cycle, so back-to-back reads produce back-to-back rvalid pulses.
- Write-then-read to the same address in consecutive cycles returns the new data; the memory's read-during-write behaviour applies only within a single cycle, which cannot happen here.
- Worst-case wait for a requester blocked while the other streams is BURST_MAX cycles.
- The critical path runs from req/address through the grant and range compare to mem_* and ack. This path has no registers.

## Test plan

- **Reset values:** reset → all outputs 0, owner=A, streak=0. Assert reset during a read accepted the cycle before → no rvalid.
- **Single read:** A writes 0xDEADBEEF to address 0x0010 with byteenable 0xF. B then reads 0x0010 → b_ack in that same cycle; b_rvalid=1 with b_readdata=0xDEADBEEF one cycle later; a_rvalid stays 0.
- **Byte enables:** write 0xFFFFFFFF, then write 0x00000000 with byteenable 0x5, then read → 0xFF00FF00.
- **Arbitration under contention:** A and B both hold req=1 continuously with BURST_MAX=16, starting from reset → A granted for 16 cycles, then B for 16, repeating; neither side ever waits more than 16 cycles.
- **Out of range:** A reads address 51200 → a_ack=1, mem_chipselect=0; next cycle a_rvalid=1, a_readdata=0, err=1; err_count=1. Sustained out-of-range accesses make err_count saturate at 0xFFFF.
- **Simultaneous events:** A read is accepted in the same cycle that B's write to a different address is pending → B is granted in the next cycle and A's rvalid coincides with B's ack. The data A receives is unaffected by B's write.
